// File: rtl/tap_ctrl.sv
// JTAG-style TAP controller: 16-state TAP FSM, 3-bit instruction register, DR select/tdo mux,
// boundary-scan chain controls and a counter-timed RUNBIST session on the BILBO chain.
module tap_ctrl #(
    parameter int unsigned IR_W        = 3,
    parameter int unsigned BIST_CYCLES = 255
) (
    input  logic clock,
    input  logic rst_l,
    input  logic tms,
    input  logic tdi,
    output logic tdo,
    output logic tdo_en,
    output logic bsr_scan_in,
    input  logic bsr_scan_out,
    output logic bsr_shift,
    output logic bsr_clk_en,
    output logic bsr_update,
    output logic bsr_sel,
    output logic bist_b1,
    output logic bist_b2,
    output logic bist_clk_en,
    input  logic bist_scan_out,
    output logic bist_done
);

    localparam int unsigned CNT_W = $clog2(BIST_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIST_CYCLES - 1);

    localparam logic [3:0] ST_TLR      = 4'h0;
    localparam logic [3:0] ST_RTI      = 4'h1;
    localparam logic [3:0] ST_SEL_DR   = 4'h2;
    localparam logic [3:0] ST_CAP_DR   = 4'h3;
    localparam logic [3:0] ST_SH_DR    = 4'h4;
    localparam logic [3:0] ST_EX1_DR   = 4'h5;
    localparam logic [3:0] ST_PAUSE_DR = 4'h6;
    localparam logic [3:0] ST_EX2_DR   = 4'h7;
    localparam logic [3:0] ST_UPD_DR   = 4'h8;
    localparam logic [3:0] ST_SEL_IR   = 4'h9;
    localparam logic [3:0] ST_CAP_IR   = 4'hA;
    localparam logic [3:0] ST_SH_IR    = 4'hB;
    localparam logic [3:0] ST_EX1_IR   = 4'hC;
    localparam logic [3:0] ST_PAUSE_IR = 4'hD;
    localparam logic [3:0] ST_EX2_IR   = 4'hE;
    localparam logic [3:0] ST_UPD_IR   = 4'hF;

    localparam logic [IR_W-1:0] IR_EXTEST  = IR_W'(0);
    localparam logic [IR_W-1:0] IR_SAMPLE  = IR_W'(1);
    localparam logic [IR_W-1:0] IR_INTEST  = IR_W'(2);
    localparam logic [IR_W-1:0] IR_RUNBIST = IR_W'(3);
    localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(1);

    logic [3:0]      state_q, state_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic [IR_W-1:0] ir_sr_q, ir_sr_d;
    logic            byp_q, byp_d;
    logic            tdo_q, tdo_d;
    logic            tdo_en_q, tdo_en_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            done_q, done_d;

    logic sel_bsr, sel_bist, bist_run, dr_out;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_TLR:      state_d = tms ? ST_TLR    : ST_RTI;
            ST_RTI:      state_d = tms ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR:   state_d = tms ? ST_SEL_IR : ST_CAP_DR;
            ST_CAP_DR:   state_d = tms ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:    state_d = tms ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR:   state_d = tms ? ST_UPD_DR : ST_PAUSE_DR;
            ST_PAUSE_DR: state_d = tms ? ST_EX2_DR : ST_PAUSE_DR;
            ST_EX2_DR:   state_d = tms ? ST_UPD_DR : ST_SH_DR;
            ST_UPD_DR:   state_d = tms ? ST_SEL_DR : ST_RTI;
            ST_SEL_IR:   state_d = tms ? ST_TLR    : ST_CAP_IR;
            ST_CAP_IR:   state_d = tms ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:    state_d = tms ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR:   state_d = tms ? ST_UPD_IR : ST_PAUSE_IR;
            ST_PAUSE_IR: state_d = tms ? ST_EX2_IR : ST_PAUSE_IR;
            ST_EX2_IR:   state_d = tms ? ST_UPD_IR : ST_SH_IR;
            ST_UPD_IR:   state_d = tms ? ST_SEL_DR : ST_RTI;
            default:     state_d = ST_TLR;
        endcase
    end

    assign sel_bsr  = (ir_q == IR_EXTEST) || (ir_q == IR_SAMPLE) || (ir_q == IR_INTEST);
    assign sel_bist = (ir_q == IR_RUNBIST);
    assign bist_run = sel_bist && (state_q == ST_RTI) && !done_q;
    assign dr_out   = sel_bsr ? bsr_scan_out : (sel_bist ? bist_scan_out : byp_q);

    always_comb begin
        ir_sr_d  = ir_sr_q;
        ir_d     = ir_q;
        byp_d    = byp_q;
        tdo_d    = tdo_q;
        tdo_en_d = 1'b0;
        cnt_d    = cnt_q;
        done_d   = done_q;

        case (state_q)
            ST_CAP_IR: ir_sr_d = IR_CAPTURE;
            ST_SH_IR: begin
                ir_sr_d  = {tdi, ir_sr_q[IR_W-1:1]};
                tdo_d    = ir_sr_q[0];
                tdo_en_d = 1'b1;
            end
            ST_UPD_IR: begin
                ir_d   = ir_sr_q;
                cnt_d  = '0;
                done_d = 1'b0;
            end
            ST_CAP_DR: byp_d = 1'b0;
            ST_SH_DR: begin
                byp_d    = tdi;
                tdo_d    = dr_out;
                tdo_en_d = 1'b1;
            end
            default: ;
        endcase

        // Counter stops on the final BIST edge; leaving RTI simply pauses it.
        if (bist_run) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST)
                done_d = 1'b1;
        end

        if (state_d == ST_TLR) begin
            ir_d   = '1;
            cnt_d  = '0;
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            state_q  <= ST_TLR;
            ir_q     <= '1;
            ir_sr_q  <= '1;
            byp_q    <= 1'b0;
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            ir_sr_q  <= ir_sr_d;
            byp_q    <= byp_d;
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign tdo         = tdo_q;
    assign tdo_en      = tdo_en_q;
    assign bsr_scan_in = tdi;
    assign bsr_clk_en  = sel_bsr && ((state_q == ST_CAP_DR) || (state_q == ST_SH_DR));
    assign bsr_shift   = sel_bsr && (state_q == ST_SH_DR);
    assign bsr_update  = sel_bsr && (state_q == ST_UPD_DR);
    assign bsr_sel     = (ir_q == IR_EXTEST) || (ir_q == IR_INTEST);
    assign bist_done   = done_q;

    always_comb begin
        bist_b1     = 1'b1;
        bist_b2     = 1'b0;
        bist_clk_en = 1'b0;
        if (bist_run) begin
            bist_b2     = 1'b1;
            bist_clk_en = 1'b1;
        end else if (sel_bist && (state_q == ST_SH_DR)) begin
            bist_b1     = 1'b0;
            bist_b2     = 1'b1;
            bist_clk_en = 1'b1;
        end
    end

endmodule

// File: tb/tb_tap_ctrl.sv
// Directed bench for tap_ctrl: reset, TLR reach, IR load, bypass, SAMPLE controls, RUNBIST session.
module tb_tap_ctrl;

    logic clock;
    logic rst_l;
    logic tms;
    logic tdi;
    logic tdo;
    logic tdo_en;
    logic bsr_scan_in;
    logic bsr_scan_out;
    logic bsr_shift;
    logic bsr_clk_en;
    logic bsr_update;
    logic bsr_sel;
    logic bist_b1;
    logic bist_b2;
    logic bist_clk_en;
    logic bist_scan_out;
    logic bist_done;

    int unsigned n_total;
    int unsigned n_bad;

    tap_ctrl #(.IR_W(3), .BIST_CYCLES(8)) dut (
        .clock        (clock),
        .rst_l        (rst_l),
        .tms          (tms),
        .tdi          (tdi),
        .tdo          (tdo),
        .tdo_en       (tdo_en),
        .bsr_scan_in  (bsr_scan_in),
        .bsr_scan_out (bsr_scan_out),
        .bsr_shift    (bsr_shift),
        .bsr_clk_en   (bsr_clk_en),
        .bsr_update   (bsr_update),
        .bsr_sel      (bsr_sel),
        .bist_b1      (bist_b1),
        .bist_b2      (bist_b2),
        .bist_clk_en  (bist_clk_en),
        .bist_scan_out(bist_scan_out),
        .bist_done    (bist_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive inputs just after an edge, then sample 1 time unit after the next edge.
    task automatic step(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge clock);
        #1;
    endtask

    // From Run-Test/Idle: shift v into IR (LSB first) and return to RTI.
    task automatic load_ir(input logic [2:0] v, input logic chk_load);
        logic [2:0] cap;
        cap = 3'b001;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(i == 2, v[i]);
            if (chk_load) begin
                check($sformatf("ir_tdo[%0d]", i), tdo, cap[i]);
                check($sformatf("ir_tdo_en[%0d]", i), tdo_en, 1'b1);
            end
        end
        step(1'b1, 1'b0);
        if (chk_load) check("bsr_sel_before_upd", bsr_sel, 1'b0);
        step(1'b0, 1'b0);
        if (chk_load) check("bsr_sel_after_upd", bsr_sel, 1'b1);
    endtask

    initial begin
        n_total       = 0;
        n_bad         = 0;
        rst_l         = 1'b0;
        tms           = 1'b1;
        tdi           = 1'b0;
        bsr_scan_out  = 1'b0;
        bist_scan_out = 1'b0;
        #12;
        check("rst_tdo", tdo, 1'b0);
        check("rst_tdo_en", tdo_en, 1'b0);
        check("rst_bsr_ctl", {bsr_shift, bsr_clk_en, bsr_update, bsr_sel}, 4'b0000);
        check("rst_b1b2", {bist_b1, bist_b2}, 2'b10);
        check("rst_bist", {bist_clk_en, bist_done}, 2'b00);
        #5 rst_l = 1'b1;
        @(posedge clock); #1;
        step(1'b0, 1'b0);

        // IR load of EXTEST with capture stream 1,0,0
        load_ir(3'b000, 1'b1);

        // async reset in the middle of EXTEST Shift-DR
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("extest_cap_clk_en", bsr_clk_en, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("extest_sh_tdo_en", tdo_en, 1'b1);
        check("extest_bsr_sel", bsr_sel, 1'b1);
        #2 rst_l = 1'b0;
        #1;
        check("arst_tdo_en", tdo_en, 1'b0);
        check("arst_bsr_sel", bsr_sel, 1'b0);
        check("arst_b1b2", {bist_b1, bist_b2}, 2'b10);
        check("arst_bsr_sh", {bsr_shift, bsr_clk_en}, 2'b00);
        #1 rst_l = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("post_arst_tdo_en", tdo_en, 1'b0);

        // 4 tms=1 edges from Shift-IR do not reach TLR, 5 do
        load_ir(3'b000, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        check("four_tms_not_tlr", bsr_sel, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("four_tms_in_shift_ir", tdo_en, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        check("four_tms_sel_kept", bsr_sel, 1'b1);
        step(1'b1, 1'b0);
        check("five_tms_tlr", bsr_sel, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("tlr_to_rti_tdo_en", tdo_en, 1'b0);

        // BYPASS: tdi 1,0,1,1 -> tdo 0,1,0,1,1
        load_ir(3'b111, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("byp_bsr_clk_en", bsr_clk_en, 1'b0);
        begin
            logic [4:0] tin;
            logic [4:0] texp;
            tin  = 5'b01101;
            texp = 5'b11010;
            for (int i = 0; i < 5; i++) begin
                step(i == 4, tin[i]);
                check($sformatf("byp_tdo[%0d]", i), tdo, texp[i]);
                check($sformatf("byp_tdo_en[%0d]", i), tdo_en, 1'b1);
            end
        end
        step(1'b1, 1'b0);
        check("byp_upd_tdo_en", tdo_en, 1'b0);
        step(1'b0, 1'b0);

        // SAMPLE: boundary chain controls
        load_ir(3'b001, 1'b0);
        check("smp_bsr_sel", bsr_sel, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("smp_cap", {bsr_clk_en, bsr_shift, bsr_update}, 3'b100);
        step(1'b0, 1'b1);
        check("smp_sh", {bsr_clk_en, bsr_shift, bsr_update}, 3'b110);
        check("smp_scan_in", bsr_scan_in, 1'b1);
        begin
            logic [2:0] bso;
            bso = 3'b101;
            for (int i = 0; i < 3; i++) begin
                bsr_scan_out = bso[i];
                step(i == 2, 1'b0);
                check($sformatf("smp_tdo[%0d]", i), tdo, bso[i]);
            end
        end
        check("smp_ex1", {bsr_clk_en, bsr_shift, bsr_update}, 3'b000);
        step(1'b1, 1'b0);
        check("smp_upd", {bsr_clk_en, bsr_shift, bsr_update}, 3'b001);
        check("smp_upd_sel", bsr_sel, 1'b0);
        step(1'b0, 1'b0);
        check("smp_upd_end", bsr_update, 1'b0);

        // RUNBIST with 8 cycles
        load_ir(3'b011, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("bist_run_b1b2[%0d]", i), {bist_b1, bist_b2, bist_clk_en, bist_done}, 4'b1110);
            step(1'b0, 1'b0);
        end
        check("bist_end", {bist_b1, bist_b2, bist_clk_en, bist_done}, 4'b1001);
        step(1'b0, 1'b0);
        check("bist_hold", {bist_b1, bist_b2, bist_clk_en, bist_done}, 4'b1001);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("bist_scan", {bist_b1, bist_b2, bist_clk_en}, 3'b011);
        check("bist_scan_bsr", bsr_clk_en, 1'b0);
        bist_scan_out = 1'b1;
        step(1'b0, 1'b0);
        check("bist_tdo0", tdo, 1'b1);
        bist_scan_out = 1'b0;
        step(1'b1, 1'b0);
        check("bist_tdo1", tdo, 1'b0);
        check("bist_ex1", {bist_b1, bist_b2, bist_clk_en, bist_done}, 4'b1001);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule
